fetch_stage: RTL

Instruction-fetch stage with the IF/ID pipeline register. It sits directly upstream of the main decoder in ID. It holds the PC and issues one outstanding request at a time on the SRAM-like instruction port. It applies branch, jump and exception redirects with MIPS delay-slot semantics, and delivers `instrD`, `pcD`, a delay-slot flag and a fetch address-error flag to ID. It honours `stallD` without losing returned data.

---
 rtl/fetch_stage_pkg.sv | 14 +
 rtl/if_id_reg.sv | 63 ++++++
 rtl/fetch_stage.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared constants and state encoding for the instruction-fetch stage.
package fetch_stage_pkg;

    localparam logic [31:0] RESET_PC  = 32'hBFC0_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: holds on stall, loads a bubble on flush or when no
// fetch is ready; kill (exception redirect) overrides stall.
module if_id_reg (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        kill,
    input  logic        load,
    input  logic [31:0] instr_in,
    input  logic [31:0] pc_in,
    input  logic        ds_in,
    input  logic        adel_in,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic        ds_out,
    output logic        adel_out
);
    import fetch_stage_pkg::*;

    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q, pc_d;
    logic        ds_q, ds_d;
    logic        adel_q, adel_d;

    always_comb begin
        instr_d = instr_q;
        pc_d    = pc_q;
        ds_d    = ds_q;
        adel_d  = adel_q;
        if (kill || (!stall && (flush || !load))) begin
            instr_d = NOP_INSTR;
            pc_d    = 32'h0;
            ds_d    = 1'b0;
            adel_d  = 1'b0;
        end else if (!stall) begin
            instr_d = instr_in;
            pc_d    = pc_in;
            ds_d    = ds_in;
            adel_d  = adel_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q <= NOP_INSTR;
            pc_q    <= 32'h0;
            ds_q    <= 1'b0;
            adel_q  <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc_q    <= pc_d;
            ds_q    <= ds_d;
            adel_q  <= adel_d;
        end
    end

    assign instr_out = instr_q;
    assign pc_out    = pc_q;
    assign ds_out    = ds_q;
    assign adel_out  = adel_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch with one outstanding SRAM-like request, MIPS delay-slot
// redirects, exception redirects with late-data cancellation, and the IF/ID register.
module fetch_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallD,
    input  logic        flushD,
    input  logic        except_flush,
    input  logic [31:0] pc_new,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        branch_inD,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic [31:0] instrD,
    output logic [31:0] pcD,
    output logic        in_delayslotD,
    output logic        adelD,
    output logic        inst_stall
);
    import fetch_stage_pkg::*;

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         redir_pend_q, redir_pend_d;
    logic [31:0]  redir_target_q, redir_target_d;
    logic         cancel_q, cancel_d;
    logic [31:0]  hold_data_q, hold_data_d;
    logic         ds_pend_q, ds_pend_d;

    logic         data_avail, deliver, adel_fire, id_load, ds_tag, outstanding;
    logic [31:0]  fetch_word, seq_pc;

    always_comb begin
        data_avail = !cancel_q &&
                     ((state_q == S_WAIT && inst_data_ok) ||
                      (state_q == S_REQ && inst_addr_ok && inst_data_ok));
        fetch_word = (state_q == S_HOLD) ? hold_data_q : inst_rdata;
        deliver    = (data_avail || state_q == S_HOLD) && !stallD && !except_flush;
        adel_fire  = state_q == S_IDLE && pc_q[1:0] != 2'b00 && !stallD && !except_flush;
        id_load    = deliver || adel_fire;
        ds_tag     = branch_inD || ds_pend_q;
        // The fetch being delivered is the delay slot when a redirect is live.
        seq_pc     = redirect_valid ? redirect_target :
                     (redir_pend_q ? redir_target_q : pc_q + 32'd4);
        outstanding = (state_q == S_WAIT && !inst_data_ok) ||
                      (state_q == S_REQ && inst_addr_ok && !inst_data_ok);

        state_d        = state_q;
        pc_d           = pc_q;
        redir_pend_d   = redir_pend_q;
        redir_target_d = redir_target_q;
        cancel_d       = cancel_q;
        hold_data_d    = hold_data_q;
        ds_pend_d      = ds_pend_q;

        if (except_flush) begin
            pc_d         = pc_new;
            redir_pend_d = 1'b0;
            ds_pend_d    = 1'b0;
            cancel_d     = outstanding;
            state_d      = outstanding ? S_WAIT : S_IDLE;
        end else begin
            if (redirect_valid && !deliver) begin
                redir_pend_d   = 1'b1;
                redir_target_d = redirect_target;
            end
            // Branch left ID before its delay slot arrived: tag the next delivery.
            if (!stallD && branch_inD && !id_load)
                ds_pend_d = 1'b1;
            if (id_load)
                ds_pend_d = 1'b0;
            if (data_avail && !deliver)
                hold_data_d = inst_rdata;

            if (deliver) begin
                pc_d         = seq_pc;
                redir_pend_d = 1'b0;
                state_d      = (seq_pc[1:0] == 2'b00) ? S_REQ : S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE: if (!stallD && pc_q[1:0] == 2'b00) state_d = S_REQ;
                    S_REQ:  if (inst_addr_ok) state_d = data_avail ? S_HOLD : S_WAIT;
                    S_WAIT: if (inst_data_ok) begin
                        if (cancel_q) begin
                            cancel_d = 1'b0;
                            state_d  = S_IDLE;
                        end else begin
                            state_d  = S_HOLD;
                        end
                    end
                    default: state_d = state_q;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            pc_q           <= RESET_PC;
            redir_pend_q   <= 1'b0;
            redir_target_q <= 32'h0;
            cancel_q       <= 1'b0;
            hold_data_q    <= NOP_INSTR;
            ds_pend_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            redir_pend_q   <= redir_pend_d;
            redir_target_q <= redir_target_d;
            cancel_q       <= cancel_d;
            hold_data_q    <= hold_data_d;
            ds_pend_q      <= ds_pend_d;
        end
    end

    assign inst_req   = state_q == S_REQ;
    assign inst_addr  = pc_q;
    assign inst_stall = state_q == S_REQ || state_q == S_WAIT || cancel_q;

    if_id_reg u_if_id (
        .clk       (clk),
        .rst       (rst),
        .stall     (stallD),
        .flush     (flushD),
        .kill      (except_flush),
        .load      (id_load),
        .instr_in  (adel_fire ? NOP_INSTR : fetch_word),
        .pc_in     (pc_q),
        .ds_in     (ds_tag),
        .adel_in   (adel_fire),
        .instr_out (instrD),
        .pc_out    (pcD),
        .ds_out    (in_delayslotD),
        .adel_out  (adelD)
    );

endmodule
